// File: rtl/mux4_rr_sched_if.sv
// Shared-path bundle between the four requesting sources and the round-robin scheduler.
interface mux4_rr_sched_if;
  logic [3:0] REQ;
  logic [3:0] IN;
  logic [3:0] GNT;
  logic [1:0] SL;
  logic       VALID;
  logic       OUT;

  modport master (output REQ, IN, input GNT, SL, VALID, OUT);
  modport slave  (input REQ, IN, output GNT, SL, VALID, OUT);
endinterface

// File: rtl/mux4_rr_sched.sv
// Round-robin owner of a shared 4:1 one-bit mux path with bounded tenure under contention
// and a registered data output.
module mux4_rr_sched #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  mux4_rr_sched_if.slave  bus
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD = CW'(MAX_HOLD);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state_q;
  logic [1:0]    ptr_q;
  logic [1:0]    sl_q;
  logic [3:0]    gnt_q;
  logic          valid_q;
  logic          out_q;
  logic [CW-1:0] cnt_q;

  logic          win_found;
  logic [1:0]    win_idx;
  logic [1:0]    scan_idx;
  logic [3:0]    others;
  logic          rel;
  logic          take;

  // Scan starts at ptr, which is always owner+1, so the current owner is examined last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      scan_idx = ptr_q + 2'(i);
      if (!win_found && bus.REQ[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    others = bus.REQ & ~gnt_q;
    rel    = !bus.REQ[sl_q] || ((cnt_q == HOLD) && (others != '0));
    take   = ((state_q == IDLE) && win_found) ||
             ((state_q == OWN) && rel && (others != '0));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sl_q    <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      out_q <= valid_q ? bus.IN[sl_q] : 1'b0;
      if (take) begin
        state_q <= OWN;
        gnt_q   <= 4'b0001 << win_idx;
        sl_q    <= win_idx;
        valid_q <= 1'b1;
        cnt_q   <= CW'(1);
        ptr_q   <= win_idx + 2'd1;
      end else if (state_q == OWN) begin
        if (rel) begin
          state_q <= IDLE;
          gnt_q   <= '0;
          valid_q <= 1'b0;
          cnt_q   <= '0;
        end else if (cnt_q != HOLD) begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign bus.GNT   = gnt_q;
  assign bus.SL    = sl_q;
  assign bus.VALID = valid_q;
  assign bus.OUT   = out_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Drives two schedulers (MAX_HOLD 8 and 1) with identical stimulus and compares both
// against an integer-level model of the arbitration rules.
module tb_mux4_rr_sched;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] req_r = '0;
  logic [3:0] in_r = '0;

  int n_assert = 0;
  int n_fail = 0;

  mux4_rr_sched_if bus8 ();
  mux4_rr_sched_if bus1 ();

  assign bus8.REQ = req_r;
  assign bus8.IN  = in_r;
  assign bus1.REQ = req_r;
  assign bus1.IN  = in_r;

  mux4_rr_sched #(.MAX_HOLD(8)) u_dut8 (.CLK(CLK), .RST_N(RST_N), .bus(bus8));
  mux4_rr_sched #(.MAX_HOLD(1)) u_dut1 (.CLK(CLK), .RST_N(RST_N), .bus(bus1));

  always #5 CLK = ~CLK;

  logic [3:0] gnt_w [2];
  logic [1:0] sl_w [2];
  logic       valid_w [2];
  logic       out_w [2];

  assign gnt_w[0] = bus8.GNT;   assign gnt_w[1] = bus1.GNT;
  assign sl_w[0] = bus8.SL;     assign sl_w[1] = bus1.SL;
  assign valid_w[0] = bus8.VALID; assign valid_w[1] = bus1.VALID;
  assign out_w[0] = bus8.OUT;   assign out_w[1] = bus1.OUT;

  // Model state: owner -1 means idle.
  int hold [2] = '{8, 1};
  int m_owner [2];
  int m_ptr [2];
  int m_cnt [2];
  int m_sl [2];
  int m_out [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1; m_ptr[d] = 0; m_cnt[d] = 0; m_sl[d] = 0; m_out[d] = 0;
    end
  endtask

  function automatic int pick(input int start, input logic [3:0] r);
    for (int i = 0; i < 4; i++)
      if (r[(start + i) % 4]) return (start + i) % 4;
    return -1;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int w;
      logic [3:0] oth;
      logic rel;
      m_out[d] = (m_owner[d] >= 0) ? int'(in_r[m_sl[d]]) : 0;
      w = pick(m_ptr[d], req_r);
      if (m_owner[d] < 0) begin
        if (w >= 0) begin
          m_owner[d] = w; m_sl[d] = w; m_cnt[d] = 1; m_ptr[d] = (w + 1) % 4;
        end
      end else begin
        oth = req_r & ~(4'b0001 << m_owner[d]);
        rel = !req_r[m_owner[d]] || (m_cnt[d] == hold[d] && oth != 0);
        if (!rel) begin
          if (m_cnt[d] < hold[d]) m_cnt[d]++;
        end else if (oth != 0) begin
          m_owner[d] = w; m_sl[d] = w; m_cnt[d] = 1; m_ptr[d] = (w + 1) % 4;
        end else begin
          m_owner[d] = -1; m_cnt[d] = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < 2; d++) begin
      logic [3:0] eg;
      eg = (m_owner[d] < 0) ? 4'b0000 : (4'b0001 << m_owner[d]);
      check({tag, (d == 0) ? "/h8 GNT" : "/h1 GNT"}, 32'(gnt_w[d]), 32'(eg));
      check({tag, (d == 0) ? "/h8 SL" : "/h1 SL"}, 32'(sl_w[d]), 32'(m_sl[d]));
      check({tag, (d == 0) ? "/h8 VALID" : "/h1 VALID"}, 32'(valid_w[d]), 32'(m_owner[d] >= 0));
      check({tag, (d == 0) ? "/h8 OUT" : "/h1 OUT"}, 32'(out_w[d]), 32'(m_out[d]));
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_all("por");
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // Reset mid-grant: outputs drop without a clock edge, arbitration restarts at 0.
    req_r = 4'b1000; in_r = 4'b1000;
    repeat (3) tick("pre_rst");
    #2;
    do_reset("rst_mid");
    req_r = 4'b1111;
    tick("rst_after");
    check("rst_after GNT0001", 32'(bus8.GNT), 32'h1);
    check("rst_after SL0", 32'(bus8.SL), 32'h0);

    // Single requester holds far beyond MAX_HOLD.
    do_reset("rst_single");
    req_r = 4'b0100; in_r = 4'b0100;
    for (int t = 1; t <= 20; t++) begin
      tick("single");
      check("single GNT", 32'(bus8.GNT), 32'h4);
      if (t >= 2) check("single OUT", 32'(bus8.OUT), 32'h1);
    end
    req_r = 4'b0000;
    tick("single_drop");
    check("single_drop VALID", 32'(bus8.VALID), 32'h0);
    tick("single_idle");

    // Full contention: 8-cycle tenures in order 0,1,2,3,0; MAX_HOLD=1 rotates every cycle.
    do_reset("rst_cont");
    req_r = 4'b1111; in_r = 4'b1010;
    for (int t = 1; t <= 40; t++) begin
      tick("cont");
      check("cont h8 order", 32'(bus8.GNT), 32'(4'b0001 << (((t - 1) / 8) % 4)));
      check("cont h1 order", 32'(bus1.GNT), 32'(4'b0001 << ((t - 1) % 4)));
      if (t >= 2) check("cont h1 OUT", 32'(bus1.OUT), 32'(t % 2));
    end
    req_r = 4'b0000;
    tick("cont_drop");
    tick("cont_after");
    check("cont_after h1 OUT", 32'(bus1.OUT), 32'h0);

    // Early release: owner 1 leaves after 3 cycles, 2 is not requesting, so 3 wins.
    do_reset("rst_early");
    req_r = 4'b0010;
    tick("early");
    req_r = 4'b1010;
    tick("early");
    tick("early");
    check("early GNT owner1", 32'(bus8.GNT), 32'h2);
    req_r = 4'b1000;
    tick("early_rel");
    check("early_rel GNT", 32'(bus8.GNT), 32'h8);

    // Pointer fairness after idling from owner 2.
    do_reset("rst_ptr");
    req_r = 4'b0100;
    tick("ptr");
    req_r = 4'b0000;
    tick("ptr_idle");
    req_r = 4'b0101;
    tick("ptr_new");
    check("ptr_new GNT", 32'(bus8.GNT), 32'h1);

    // Randomized traffic with slowly changing requests.
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 3) == 0) req_r = 4'($urandom_range(0, 15));
      in_r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        #2;
        do_reset("rnd_rst");
      end else begin
        tick("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_sched.md
# mux4_rr_sched

Round-robin scheduler that shares one 4:1 one-bit mux path among four requesters. It arbitrates the `REQ[3:0]` lines, drives the mux select `SL[1:0]` and a one-hot `GNT[3:0]`, and limits each owner's tenure to `MAX_HOLD` cycles while others are waiting. It also contains the selected data path itself, so downstream logic sees a registered `OUT` together with the grant state. It sits between the requesting sources and the consumer of the shared line.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles for one owner while another request is pending. Legal range is 1..255.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RST_N` in 1: asynchronous reset, active low.
- `REQ` in 4: request per source; bit i set means source i wants the path.
- `IN` in 4: data bit per source; `IN[i]` is routed when source i owns the path.
- `GNT` out 4: one-hot grant, or all zero when idle.
- `SL` out 2: binary index of the current owner; drives the mux select.
- `VALID` out 1: set when a grant is active (`GNT != 0`).
- `OUT` out 1: registered muxed data.

## Operation
- **State machine:** two states, `IDLE` and `OWN`. Holder registers:
  - `ptr[1:0]`: round-robin start index.
  - `cnt`: tenure counter, width ceil(log2(MAX_HOLD+1)).
- **Winner function:** the first set bit of `REQ` scanning `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4).
- **IDLE:**
  - If `REQ == 0`, stay in `IDLE`.
  - Otherwise, at the edge: `GNT <= onehot(w)`, `SL <= w`, `VALID <= 1`, `cnt <= 1`, `ptr <= w+1` mod 4. Go to `OWN`.
- **OWN, owner o.** Release occurs when either condition holds at the edge:
  - `REQ[o] == 0`, or
  - `cnt == MAX_HOLD` and `(REQ & ~onehot(o)) != 0`.
- **No release:** `cnt <= cnt+1`, saturating at `MAX_HOLD`. An owner that is alone may therefore hold indefinitely.
- **Release with `REQ & ~onehot(o)` nonzero:** hand off directly to the winner in the same edge, with no idle bubble. The scan starts from `ptr` (= o+1), so o is never re-picked. Apply the `IDLE` grant updates.
- **Release with no other request:** `GNT <= 0`, `VALID <= 0`, `SL` holds its value, `cnt <= 0`, `ptr` unchanged. Go to `IDLE`.
- **Data path:** every edge, `OUT <= VALID ? IN[SL] : 0`, using the registered `VALID` and `SL` present before the edge.
- **Output invariants:** `GNT` is always one-hot or zero. `VALID == |GNT`. `SL` is the index of the set `GNT` bit whenever `VALID` is 1.

## Timing
- **Reset** (`RST_N` low, async):
  - `GNT = 0`, `SL = 0`, `VALID = 0`, `OUT = 0`.
  - `ptr = 0`, `cnt = 0`, state `IDLE`.
  - These values take effect immediately, without a clock edge.
- **Reset mid-grant:** the grant is dropped at once. After deassertion, arbitration restarts from `ptr = 0`.
- **Grant latency:** `REQ` sampled at edge k gives `GNT`/`SL`/`VALID` valid after edge k. `OUT` reflects the granted `IN` after edge k+1.
- **Release latency:** the owner drops `REQ` before edge k; `GNT` changes after edge k. The last `OUT` sample from that owner appears after edge k.
- **Hand-off:** back-to-back, with zero cycles where `VALID` is 0, whenever others are pending.
- **Tenure:** a contended owner holds exactly `MAX_HOLD` cycles of `VALID`. `MAX_HOLD = 1` rotates grants every cycle.
- **Simultaneous requests:** resolved purely by `ptr`. No fixed priority survives past the first grant.

## Test plan
- **Reset:** assert `RST_N = 0` mid-grant.
  - Required: all outputs 0 asynchronously.
  - After release, with `REQ = 4'b1111`: `GNT = 4'b0001`, `SL = 0`.
- **Single requester:** `REQ = 4'b0100`, `IN = 4'b0100`, held 20 cycles.
  - Required: `GNT = 4'b0100`, `SL = 2`, `VALID` = 1 for the whole period (no timeout).
  - `OUT = 1` from the second cycle on.
  - Dropping `REQ` gives `VALID = 0` the next cycle.
- **Full contention:** `MAX_HOLD = 8`, `REQ = 4'b1111` constant.
  - Required: grant order 0,1,2,3,0, each lasting exactly 8 cycles, with no idle cycle between grants.
- **Early release:** owner 1 drops `REQ` after 3 cycles while `REQ[3]` is set.
  - Required: `GNT` goes `0010` to `1000` on the next edge, skipping 2 because `REQ[2]` is 0.
- **Data routing:** grant rotates with `MAX_HOLD = 1`, `IN = 4'b1010`.
  - Required: `OUT` sequence 0,1,0,1, lagging `SL` by one cycle.
  - `OUT = 0` on the cycle after `VALID` falls.
- **Fairness/pointer:** the last grant was 2, the block went idle, then `REQ = 4'b0101` arrives.
  - Required: source 0 is granted first (`ptr = 3`, so the scan order is 3,0,1,2).
